stopwatch_ctrl: RTL

Sequencing controller for a chain of cascaded BCD digit counters in the stopwatch datapath. It turns debounced start/stop and lap/reset button pulses into a run/pause/lap state machine. A prescaler in the block produces one-cycle `count_en` pulses that drive `increase` of the least-significant digit. It clears the chain through `load_default`, freezes the display during lap, and latches overflow from the most-significant digit's carry.

---
 rtl/stopwatch_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// stopwatch_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for a chain of cascaded BCD digit counters. Debounced
// start/stop and lap/reset pulses drive a run/pause/lap state machine. An
// internal prescaler produces one-cycle count enables for the least
// significant digit. The block also clears the whole chain, freezes the
// display during a lap, and latches overflow from the top digit's carry.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : LAP state reachable, lap_freeze driven by the FSM
//   undefined : LAP unreachable, lap_freeze tied low, lap_reset in RUN ignored
//
// Parameters
//   TICK_DIV     : clock cycles per count increment (must be >= 2)
//
// Ports
//   clk          : in  1  global clock, rising edge
//   rst_n        : in  1  asynchronous active-low reset
//   start_stop   : in  1  debounced single-cycle pulse, toggles run/pause
//   lap_reset    : in  1  debounced single-cycle pulse, lap (running) or
//                         clear (stopped)
//   top_carry    : in  1  carry out of the most significant digit counter
//   count_en     : out 1  registered one-cycle pulse to LSD 'increase'
//   load_default : out 1  registered, only ever high together with count_en,
//                         makes the chain load its default (zero) value
//   lap_freeze   : out 1  registered display-latch hold
//   ovf          : out 1  sticky overflow flag
//   state        : out 2  IDLE=00, RUN=01, PAUSE=10, LAP=11
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       lap_reset,
    input  logic       top_carry,
    output logic       count_en,
    output logic       load_default,
    output logic       lap_freeze,
    output logic       ovf,
    output logic [1:0] state
);

    // Prescaler width; guarded so a degenerate parameter still elaborates.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          count_en_q, count_en_d;
    logic          load_q, load_d;
    logic          ovf_q, ovf_d;

    logic          clear;
    logic          overflow;
    logic          running_q;
    logic          running_d;
    logic          advance;
    logic          wrap;

    // The carry is only meaningful in a cycle where the chain is actually
    // incrementing, so it is qualified by the registered enable.
    assign overflow = count_en_q & top_carry;

    // ------------------------------------------------------------------------
    // Next-state logic. Within every state overflow beats both buttons, and
    // start_stop beats lap_reset when both arrive together.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end else if (lap_reset) begin
                    clear = 1'b1;
                    ovf_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (overflow) begin
                    state_d = ST_PAUSE;
                    ovf_d   = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_reset) begin
                    state_d = ST_LAP;
                end
`endif
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end else if (lap_reset) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (overflow) begin
                    state_d = ST_PAUSE;
                    ovf_d   = 1'b1;
                end else if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap_reset) begin
                    state_d = ST_RUN;
                end
`else
                // Unreachable without the lap feature; recover to IDLE.
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Prescaler. It only advances when the FSM is counting now and will still
    // be counting next cycle. Leaving RUN/LAP for PAUSE therefore freezes the
    // value seen in the button cycle, and PAUSE->RUN resumes from exactly
    // that value, so a partial tick is never lost or double counted. Any
    // entry into or stay in IDLE zeroes it so a fresh run starts on a full
    // period.
    // ------------------------------------------------------------------------
    always_comb begin
        running_q = (state_q == ST_RUN) || (state_q == ST_LAP);
        running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
        advance   = running_q && running_d;
        wrap      = advance && (presc_q == PRESC_MAX);

        if (advance) begin
            presc_d = wrap ? '0 : presc_q + PRESC_ONE;
        end else if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q;
        end
    end

    // ------------------------------------------------------------------------
    // Output pulses. A clear has to ride on count_en because the digit
    // counters only load while 'increase' is high.
    // ------------------------------------------------------------------------
    always_comb begin
        count_en_d = wrap | clear;
        load_d     = clear;
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            count_en_q <= 1'b0;
            load_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_en_q <= count_en_d;
            load_q     <= load_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic freeze_q, freeze_d;

    // The display hold simply tracks residence in LAP, one cycle registered
    // so it lines up with the state output.
    always_comb begin
        freeze_d = (state_d == ST_LAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end

    assign lap_freeze = freeze_q;
`else
    assign lap_freeze = 1'b0;
`endif

    assign state        = state_q;
    assign count_en     = count_en_q;
    assign load_default = load_q;
    assign ovf          = ovf_q;

endmodule
